// File: rtl/mem_array_ctrl_if.sv
// Request/response bus of the memory array controller.
// The parity_err signal exists only when MEM_PARITY_EN is defined.
interface mem_array_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
`ifdef MEM_PARITY_EN
    logic              parity_err;

    modport master (output req, we, addr, wdata,
                    input  ready, ack, rdata, busy, parity_err);
    modport slave  (input  req, we, addr, wdata,
                    output ready, ack, rdata, busy, parity_err);
`else
    modport master (output req, we, addr, wdata,
                    input  ready, ack, rdata, busy);
    modport slave  (input  req, we, addr, wdata,
                    output ready, ack, rdata, busy);
`endif
endinterface

// File: rtl/mem_array_ctrl.sv
// Single-port word array with a post-reset zero-fill sequence and a one-cycle response.
// Optional feature: MEM_PARITY_EN adds one even-parity bit per word and the parity_err output.
module mem_array_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int INIT_CLEAR = 1
) (
    input  logic             clock,
    input  logic             reset,
    mem_array_ctrl_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : IDLE;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              ready_r;
    logic              ack_r;
    logic              busy_r;
    logic [DATA_W-1:0] rdata_r;
    logic              accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    function automatic logic parity_f(input logic [DATA_W-1:0] data);
        return ^data;
    endfunction

    // Next-state decode and selection of the single array write port.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.addr;
        mem_wdata_s = bus.wdata;
        case (state_r)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_r;
                mem_wdata_s = {DATA_W{1'b0}};
                if (clr_cnt_r == LAST_ADDR) begin
                    state_s = IDLE;
                end else begin
                    state_s = CLEAR;
                end
            end
            IDLE: begin
                if (bus.req) begin
                    accept_s = 1'b1;
                    mem_we_s = bus.we;
                    state_s  = RESP;
                end else begin
                    state_s  = IDLE;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = RST_STATE;
        endcase
    end

    // State register and clear address counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= RST_STATE;
            clr_cnt_r <= {ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (state_r == CLEAR) begin
                clr_cnt_r <= clr_cnt_r + ADDR_ONE;
            end
        end
    end

    // Outputs are registered from the next state so they align with the state they describe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_r <= (INIT_CLEAR == 0);
            busy_r  <= (INIT_CLEAR != 0);
            ack_r   <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            ready_r <= (state_s == IDLE);
            busy_r  <= (state_s == CLEAR);
            ack_r   <= accept_s;
            if (accept_s && !bus.we) begin
                rdata_r <= mem_r[bus.addr];
            end
        end
    end

    // Array storage is deliberately not reset; only CLEAR or a write changes it.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

`ifdef MEM_PARITY_EN
    logic par_r [DEPTH];
    logic parity_err_r;

    // Parity bit per word; zero data from CLEAR yields a zero parity bit.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            par_r[mem_waddr_s] <= parity_f(mem_wdata_s);
        end
    end

    // Flag a mismatch only alongside the ack of a read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= accept_s && !bus.we &&
                            (parity_f(mem_r[bus.addr]) != par_r[bus.addr]);
        end
    end

    assign bus.parity_err = parity_err_r;
`endif

    assign bus.ready = ready_r;
    assign bus.ack   = ack_r;
    assign bus.rdata = rdata_r;
    assign bus.busy  = busy_r;
endmodule
